// File: rtl/icx_spi_slave_pkg.sv
// -----------------------------------------------------------------------------
// icx_spi_slave_pkg
// Shared definitions for the channel-FPGA end of the ICX serial control link:
// FSM state encoding, serial word length and synchronizer depth.
// -----------------------------------------------------------------------------
package icx_spi_slave_pkg;

    // Serial word length of the main FPGA's SPI master.
    localparam int WORD_W     = 16;

    // Flops between an asynchronous pin and its first use.
    localparam int SYNC_DEPTH = 2;

    // Bit counter width; wraps to 0 naturally after the last bit of a word.
    localparam int BIT_CNT_W  = $clog2(WORD_W);

    // Width of the saturating partial-word error counter.
    localparam int ERR_CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

endpackage : icx_spi_slave_pkg

// File: rtl/icx_sync_edge.sv
// -----------------------------------------------------------------------------
// icx_sync_edge
// Multi-flop synchronizer for one asynchronous input, plus one extra register
// that compares successive synchronized values to produce registered edges.
//
// Ports:
//   clk    in   sampling clock
//   rst_n  in   synchronous active-low reset
//   din    in   asynchronous input
//   level  out  synchronized level
//   rise   out  one-cycle pulse, registered, on a synchronized 0->1
//   fall   out  one-cycle pulse, registered, on a synchronized 1->0
// -----------------------------------------------------------------------------
module icx_sync_edge
    import icx_spi_slave_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_DEPTH-1:0] sync_q, sync_d;
    logic                  prev_q, prev_d;
    logic                  rise_q, rise_d;
    logic                  fall_q, fall_d;

    always_comb begin
        sync_d = {sync_q[SYNC_DEPTH-2:0], din};
        prev_d = sync_q[SYNC_DEPTH-1];
        rise_d =  sync_q[SYNC_DEPTH-1] & ~prev_q;
        fall_d = ~sync_q[SYNC_DEPTH-1] &  prev_q;
    end

    // NOTE: non-blocking assignments in clocked blocks so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the
    // synchronizer chain into a single flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign level = sync_q[SYNC_DEPTH-1];
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule : icx_sync_edge

// File: rtl/icx_spi_slave.sv
// -----------------------------------------------------------------------------
// icx_spi_slave
// Write-only SPI slave for the inter-FPGA control link. Oversamples CS/CLK/DAT
// in the local clock domain, decodes frames of one address word followed by
// any number of data words, and emits single-cycle register write strobes with
// an auto-incrementing address.
//
// Optional feature macro: ICX_SPI_ERRCNT_EN
//   defined   -> err_cnt port present, counts frames ending on a partial word
//   undefined -> no err_cnt port, partial words silently discarded
//
// Ports:
//   wb_clk      in   local clock
//   wb_rst      in   synchronous active-low reset
//   spi_cs      in   frame select, active low, asynchronous
//   spi_clk     in   serial clock, idle low, asynchronous
//   spi_dat     in   serial data, MSB first, sampled on spi_clk rise
//   reg_adr     out  write address (ADR_W bits)
//   reg_dat     out  write data (16 bits)
//   reg_we      out  one-cycle write strobe
//   frame_done  out  one-cycle pulse at every frame end
//   busy        out  high while a frame is being decoded
//   err_cnt     out  saturating partial-word frame count (macro only)
// -----------------------------------------------------------------------------
module icx_spi_slave
    import icx_spi_slave_pkg::*;
#(
    parameter int ADR_W = 8,
    parameter int DAT_W = WORD_W   // tied to the master's word length
) (
    input  logic             wb_clk,
    input  logic             wb_rst,
    input  logic             spi_cs,
    input  logic             spi_clk,
    input  logic             spi_dat,
    output logic [ADR_W-1:0] reg_adr,
    output logic [DAT_W-1:0] reg_dat,
    output logic             reg_we,
    output logic             frame_done,
    output logic             busy
`ifdef ICX_SPI_ERRCNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    // ------------------------------------------------------------------
    // Input synchronization
    // ------------------------------------------------------------------
    logic cs_level,  cs_rise,  cs_fall;
    logic clk_level, clk_rise, clk_fall;
    logic dat_level, dat_rise, dat_fall;

    icx_sync_edge u_sync_cs (
        .clk   (wb_clk),
        .rst_n (wb_rst),
        .din   (spi_cs),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    icx_sync_edge u_sync_clk (
        .clk   (wb_clk),
        .rst_n (wb_rst),
        .din   (spi_clk),
        .level (clk_level),
        .rise  (clk_rise),
        .fall  (clk_fall)
    );

    // Data is only ever sampled as a level; its pin is stable for several
    // clocks around the spi_clk rise, so the synchronized level at the time
    // the registered clock edge arrives is the bit the master sent.
    icx_sync_edge u_sync_dat (
        .clk   (wb_clk),
        .rst_n (wb_rst),
        .din   (spi_dat),
        .level (dat_level),
        .rise  (dat_rise),
        .fall  (dat_fall)
    );

    // ------------------------------------------------------------------
    // Frame decoder state
    // ------------------------------------------------------------------
    state_e                 state_q,      state_d;
    logic [WORD_W-1:0]      shift_q,      shift_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q,    bit_cnt_d;
    logic [ADR_W-1:0]       reg_adr_q,    reg_adr_d;
    logic [DAT_W-1:0]       reg_dat_q,    reg_dat_d;
    logic                   reg_we_q,     reg_we_d;
    logic                   frame_done_q, frame_done_d;
    logic                   partial_abort;

    // Word as it will look once the bit currently being clocked is shifted in.
    logic [WORD_W-1:0]      word;
    assign word = {shift_q[WORD_W-2:0], dat_level};

    // NOTE: every signal written below gets its hold value first, so no path
    // through the case/if tree leaves one unassigned and infers a latch.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        reg_adr_d     = reg_adr_q;
        reg_dat_d     = reg_dat_q;
        reg_we_d      = 1'b0;
        frame_done_d  = 1'b0;
        partial_abort = 1'b0;

        // Post-increment: the consumer sees the address of the write that
        // just happened, then it moves on for the next word.
        if (reg_we_q) begin
            reg_adr_d = reg_adr_q + ADR_W'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                // Only a fresh falling edge opens a frame, so CS already low
                // out of reset (mid-frame) is never decoded.
                if (cs_fall) begin
                    state_d   = ST_ADDR;
                    bit_cnt_d = '0;
                end
            end

            ST_ADDR, ST_DATA: begin
                // CS rise takes priority over a coincident clock edge; the
                // count before that edge decides whether a word was cut off.
                if (cs_rise) begin
                    state_d       = ST_IDLE;
                    frame_done_d  = 1'b1;
                    partial_abort = (bit_cnt_q != '0);
                    bit_cnt_d     = '0;
                end else if (clk_rise) begin
                    shift_d   = word;
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    if (bit_cnt_q == BIT_CNT_W'(WORD_W - 1)) begin
                        if (state_q == ST_ADDR) begin
                            reg_adr_d = word[ADR_W-1:0];
                            state_d   = ST_DATA;
                        end else begin
                            reg_dat_d = word;
                            reg_we_d  = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (!wb_rst) begin
            state_q      <= ST_IDLE;
            // NOTE: the shift register is a handful of flops, not a RAM, so
            // it is reset along with everything else and never holds bits
            // left over from a frame interrupted by reset.
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            reg_adr_q    <= '0;
            reg_dat_q    <= '0;
            reg_we_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            reg_adr_q    <= reg_adr_d;
            reg_dat_q    <= reg_dat_d;
            reg_we_q     <= reg_we_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign reg_adr    = reg_adr_q;
    assign reg_dat    = reg_dat_q;
    assign reg_we     = reg_we_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != ST_IDLE);

    // ------------------------------------------------------------------
    // Partial-word error counter
    // ------------------------------------------------------------------
`ifdef ICX_SPI_ERRCNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (partial_abort && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge wb_clk) begin
        if (!wb_rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;

    logic unused_sync;
    assign unused_sync = ^{cs_level, clk_level, clk_fall, dat_rise, dat_fall,
                           shift_q[WORD_W-1]};
`else
    // Without the counter the abort flag has no consumer.
    logic unused_sync;
    assign unused_sync = ^{cs_level, clk_level, clk_fall, dat_rise, dat_fall,
                           shift_q[WORD_W-1], partial_abort};
`endif

endmodule : icx_spi_slave

// File: tb/tb_icx_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_icx_spi_slave
// Self-checking bench for icx_spi_slave. A frame is modelled as a flat bit
// stream: the first full word is the address, every further full word is one
// write to address+index, and a stream length that is not a multiple of 16
// is a partial-word error.
// -----------------------------------------------------------------------------
module tb_icx_spi_slave;

    localparam int ADR_W = 8;
    localparam int ADR_MOD = 1 << ADR_W;
    // Pin change lands before posedge E0; output registers after E3.
    localparam int EXP_LAT = 4;

    logic             wb_clk  = 1'b0;
    logic             wb_rst  = 1'b0;
    logic             spi_cs  = 1'b1;
    logic             spi_clk = 1'b0;
    logic             spi_dat = 1'b0;
    logic [ADR_W-1:0] reg_adr;
    logic [15:0]      reg_dat;
    logic             reg_we;
    logic             frame_done;
    logic             busy;
`ifdef ICX_SPI_ERRCNT_EN
    logic [7:0]       err_cnt;
`endif

    int checks  = 0;
    int errors  = 0;
    int exp_err = 0;
    int half    = 5;

    always #4 wb_clk = ~wb_clk;

    icx_spi_slave #(.ADR_W(ADR_W)) dut (
        .wb_clk     (wb_clk),
        .wb_rst     (wb_rst),
        .spi_cs     (spi_cs),
        .spi_clk    (spi_clk),
        .spi_dat    (spi_dat),
        .reg_adr    (reg_adr),
        .reg_dat    (reg_dat),
        .reg_we     (reg_we),
        .frame_done (frame_done),
        .busy       (busy)
`ifdef ICX_SPI_ERRCNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    // ------------------------------------------------------------------
    // Monitor: collects observed writes and frame ends with their latency
    // ------------------------------------------------------------------
    typedef struct {
        logic [ADR_W-1:0] adr;
        logic [15:0]      dat;
        int unsigned      lat;
    } wr_t;

    wr_t         wr_q[$];
    int unsigned fd_lat_q[$];
    int unsigned cyc = 0;
    int unsigned last_rise_cyc = 0;
    int unsigned cs_rise_cyc = 0;
    int          fd_cnt = 0;
    int          busy_cyc = 0;

    always @(posedge wb_clk) cyc <= cyc + 1;

    always @(negedge wb_clk) begin
        if (reg_we)     wr_q.push_back('{reg_adr, reg_dat, cyc - last_rise_cyc});
        if (frame_done) begin
            fd_cnt <= fd_cnt + 1;
            fd_lat_q.push_back(cyc - cs_rise_cyc);
        end
        if (busy)       busy_cyc <= busy_cyc + 1;
    end

    // ------------------------------------------------------------------
    // SPI master model (pins change on wb_clk negedges)
    // ------------------------------------------------------------------
    logic [15:0] fw[$];   // words of the frame under test

    task automatic spi_bit(input logic b);
        spi_dat = b;
        repeat (half) @(negedge wb_clk);
        spi_clk = 1'b1;
        last_rise_cyc = cyc;
        repeat (half) @(negedge wb_clk);
        spi_clk = 1'b0;
    endtask

    task automatic cs_low();
        @(negedge wb_clk);
        spi_cs = 1'b0;
        repeat (half) @(negedge wb_clk);
    endtask

    task automatic cs_high();
        repeat (half) @(negedge wb_clk);
        spi_cs = 1'b1;
        cs_rise_cyc = cyc;
    endtask

    task automatic settle();
        repeat (10) @(negedge wb_clk);
    endtask

    function automatic logic fw_bit(input int i);
        logic [15:0] w;
        w = fw[i / 16];
        return w[15 - (i % 16)];
    endfunction

    // Drives the first nbits of fw as one frame and scores it against the
    // bit-stream model.
    task automatic run_frame(input int nbits, input string name);
        int               fd0, bc0, nfull, exp_nwr, a0;
        logic [ADR_W-1:0] ea;
        wr_q.delete();
        fd_lat_q.delete();
        fd0 = fd_cnt;
        bc0 = busy_cyc;
        cs_low();
        for (int i = 0; i < nbits; i++) spi_bit(fw_bit(i));
        cs_high();
        settle();

        nfull   = nbits / 16;
        exp_nwr = (nfull > 1) ? nfull - 1 : 0;
        a0      = int'(fw[0]) % ADR_MOD;
        if ((nbits % 16) != 0 && exp_err < 255) exp_err++;

        checks++;
        if (wr_q.size() !== exp_nwr) begin
            errors++;
            $display("FAIL %s write count got %0d exp %0d", name, wr_q.size(), exp_nwr);
        end
        for (int k = 0; k < exp_nwr && k < wr_q.size(); k++) begin
            ea = ADR_W'((a0 + k) % ADR_MOD);
            checks++;
            if (wr_q[k].adr !== ea || wr_q[k].dat !== fw[k + 1]) begin
                errors++;
                $display("FAIL %s write%0d got %h/%h exp %h/%h", name, k,
                         wr_q[k].adr, wr_q[k].dat, ea, fw[k + 1]);
            end
            checks++;
            if (wr_q[k].lat !== EXP_LAT) begin
                errors++;
                $display("FAIL %s write%0d latency got %0d exp %0d", name, k, wr_q[k].lat, EXP_LAT);
            end
        end
        checks++;
        if (fd_cnt - fd0 !== 1) begin
            errors++;
            $display("FAIL %s frame_done count got %0d exp 1", name, fd_cnt - fd0);
        end
        if (fd_lat_q.size() > 0) begin
            checks++;
            if (fd_lat_q[0] !== EXP_LAT) begin
                errors++;
                $display("FAIL %s frame_done latency got %0d exp %0d", name, fd_lat_q[0], EXP_LAT);
            end
        end
        checks++;
        if ((busy_cyc - bc0 > 0) !== 1'b1 || busy !== 1'b0 || reg_we !== 1'b0) begin
            errors++;
            $display("FAIL %s busy/idle got busy_cycles=%0d busy=%b we=%b exp >0/0/0",
                     name, busy_cyc - bc0, busy, reg_we);
        end
`ifdef ICX_SPI_ERRCNT_EN
        checks++;
        if (err_cnt !== 8'(exp_err)) begin
            errors++;
            $display("FAIL %s err_cnt got %0d exp %0d", name, err_cnt, exp_err);
        end
`endif
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        repeat (5) @(negedge wb_clk);
        checks++;
        if (reg_adr !== '0 || reg_dat !== '0 || reg_we !== 1'b0 ||
            frame_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_in got adr=%h dat=%h we=%b fd=%b busy=%b exp all 0",
                     reg_adr, reg_dat, reg_we, frame_done, busy);
        end
        wb_rst = 1'b1;
        repeat (6) @(negedge wb_clk);
        checks++;
        if (reg_we !== 1'b0 || busy !== 1'b0 || fd_cnt !== 0 || wr_q.size() !== 0) begin
            errors++;
            $display("FAIL reset_out got we=%b busy=%b fd=%0d wr=%0d exp 0/0/0/0",
                     reg_we, busy, fd_cnt, wr_q.size());
        end
`ifdef ICX_SPI_ERRCNT_EN
        checks++;
        if (err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_err_cnt got %0d exp 0", err_cnt);
        end
`endif
    endtask

    task automatic test_single_write();
        fw = {16'h0012, 16'hBEEF};
        run_frame(32, "single_write");
    endtask

    task automatic test_multi_wrap();
        fw = {16'h00FE, 16'h1111, 16'h2222, 16'h3333};
        run_frame(64, "multi_wrap");
    endtask

    task automatic test_partial_word();
        fw = {16'h0005, 16'hAAAA, 16'h5A5A};
        run_frame(39, "partial_word");
        fw = {16'h0077};
        run_frame(16, "addr_only");
    endtask

    task automatic test_reset_mid_frame();
        int fd0;
        fw = {16'h0033, 16'h5555, 16'hCCCC, 16'h0F0F};
        wr_q.delete();
        fd0 = fd_cnt;
        cs_low();
        for (int i = 0; i < 20; i++) spi_bit(fw_bit(i));
        @(negedge wb_clk);
        wb_rst = 1'b0;
        repeat (2) @(negedge wb_clk);
        wb_rst = 1'b1;
        exp_err = 0;
        for (int i = 20; i < 60; i++) spi_bit(fw_bit(i));
        cs_high();
        settle();
        checks++;
        if (wr_q.size() !== 0 || fd_cnt - fd0 !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_frame got wr=%0d fd=%0d busy=%b exp 0/0/0",
                     wr_q.size(), fd_cnt - fd0, busy);
        end
        checks++;
        if (reg_adr !== '0 || reg_dat !== '0) begin
            errors++;
            $display("FAIL reset_mid_frame regs got %h/%h exp 00/0000", reg_adr, reg_dat);
        end
`ifdef ICX_SPI_ERRCNT_EN
        checks++;
        if (err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_frame err_cnt got %0d exp 0", err_cnt);
        end
`endif
        fw = {16'h0001, 16'h0042};
        run_frame(32, "after_reset");
    endtask

    task automatic test_clk_while_idle();
        int fd0, bc0;
        wr_q.delete();
        fd0 = fd_cnt;
        bc0 = busy_cyc;
        for (int i = 0; i < 16; i++) spi_bit(1'($urandom_range(0, 1)));
        settle();
        checks++;
        if (wr_q.size() !== 0 || fd_cnt - fd0 !== 0 || busy_cyc - bc0 !== 0) begin
            errors++;
            $display("FAIL clk_idle got wr=%0d fd=%0d busy_cycles=%0d exp 0/0/0",
                     wr_q.size(), fd_cnt - fd0, busy_cyc - bc0);
        end
    endtask

    // Last clock rise of a word coincides with CS rise: CS must win.
    task automatic test_cs_clk_collision();
        int fd0;
        fw = {16'h00AB, 16'h1234};
        wr_q.delete();
        fd_lat_q.delete();
        fd0 = fd_cnt;
        cs_low();
        for (int i = 0; i < 31; i++) spi_bit(fw_bit(i));
        spi_dat = fw_bit(31);
        repeat (half) @(negedge wb_clk);
        spi_clk = 1'b1;
        spi_cs  = 1'b1;
        cs_rise_cyc = cyc;
        repeat (half) @(negedge wb_clk);
        spi_clk = 1'b0;
        settle();
        if (exp_err < 255) exp_err++;
        checks++;
        if (wr_q.size() !== 0 || fd_cnt - fd0 !== 1) begin
            errors++;
            $display("FAIL collision got wr=%0d fd=%0d exp 0/1", wr_q.size(), fd_cnt - fd0);
        end
`ifdef ICX_SPI_ERRCNT_EN
        checks++;
        if (err_cnt !== 8'(exp_err)) begin
            errors++;
            $display("FAIL collision err_cnt got %0d exp %0d", err_cnt, exp_err);
        end
`endif
    endtask

    task automatic test_random();
        for (int f = 0; f < 12; f++) begin
            half = $urandom_range(5, 8);
            fw.delete();
            for (int w = 0; w < 6; w++) fw.push_back(16'($urandom));
            run_frame($urandom_range(0, 80), $sformatf("random%0d", f));
        end
        half = 5;
    endtask

    task automatic test_err_saturation();
        int fd0;
        wr_q.delete();
        fd0 = fd_cnt;
        for (int f = 0; f < 300; f++) begin
            cs_low();
            for (int i = 0; i < 3; i++) spi_bit(1'($urandom_range(0, 1)));
            cs_high();
            if (exp_err < 255) exp_err++;
        end
        settle();
        checks++;
        if (wr_q.size() !== 0 || fd_cnt - fd0 !== 300) begin
            errors++;
            $display("FAIL saturation got wr=%0d fd=%0d exp 0/300", wr_q.size(), fd_cnt - fd0);
        end
`ifdef ICX_SPI_ERRCNT_EN
        checks++;
        if (err_cnt !== 8'd255) begin
            errors++;
            $display("FAIL saturation err_cnt got %0d exp 255", err_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_multi_wrap();
        test_partial_word();
        test_reset_mid_frame();
        test_clk_while_idle();
        test_cs_clk_collision();
        test_random();
        test_err_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_icx_spi_slave
